// File: rtl/prio_enc_scan.sv
// Registered N-input priority encoder with optional sticky hold and a
// time-multiplexed active-low seven-segment display that shows the index in decimal.
module prio_enc_scan #(
  parameter  int unsigned N        = 16,
  parameter  int unsigned DIGITS   = 2,
  parameter  int unsigned SCAN_DIV = 1000,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      x,
  input  logic              hold,
  input  logic              clr,
  output logic [IW-1:0]     y,
  output logic              valid,
  output logic              chg,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [N-1:0]  x_q;
  logic          en_q;
  logic          latched;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] y_nxt;
  logic          valid_nxt;
  logic          latched_nxt;
  logic [CW-1:0] scan_cnt;
  logic [DW-1:0] dig;
  logic [3:0]    digit_val;
  int unsigned   rem;

  function automatic logic [7:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    pat = 8'b11111100;
      4'd1:    pat = 8'b01100000;
      4'd2:    pat = 8'b11011010;
      4'd3:    pat = 8'b11110010;
      4'd4:    pat = 8'b01100110;
      4'd5:    pat = 8'b10110110;
      4'd6:    pat = 8'b10111110;
      4'd7:    pat = 8'b11100000;
      4'd8:    pat = 8'b11111110;
      4'd9:    pat = 8'b11110110;
      default: pat = 8'b00000000;
    endcase
  endfunction

  // Ascending scan so the highest set bit wins.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x_q[i]) top_idx = IW'(i);
    end
  end

  // Sticky result is kept only while hold stays high; dropping hold resumes tracking at once.
  always_comb begin
    y_nxt       = y;
    valid_nxt   = valid;
    latched_nxt = latched;
    if (clr) begin
      y_nxt       = '0;
      valid_nxt   = 1'b0;
      latched_nxt = 1'b0;
    end else if (!(latched && hold)) begin
      latched_nxt = 1'b0;
      if (!en_q || (x_q == '0)) begin
        y_nxt     = '0;
        valid_nxt = 1'b0;
      end else begin
        y_nxt       = top_idx;
        valid_nxt   = 1'b1;
        latched_nxt = hold;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      en_q    <= 1'b0;
      y       <= '0;
      valid   <= 1'b0;
      latched <= 1'b0;
      chg     <= 1'b0;
    end else begin
      x_q     <= x;
      en_q    <= en;
      y       <= y_nxt;
      valid   <= valid_nxt;
      latched <= latched_nxt;
      chg     <= ({valid_nxt, y_nxt} != {valid, y});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig      <= (dig == DW'(DIGITS - 1)) ? '0 : dig + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Decimal digit of y selected by the current scan position.
  always_comb begin
    rem       = 32'(y);
    digit_val = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (DW'(k) == dig) digit_val = 4'(rem % 10);
      rem = rem / 10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      an  <= ~(DIGITS'(1) << dig);
      seg <= valid ? ~pat(digit_val) : 8'b11111101;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Bench for prio_enc_scan: vector table through a latency-2 scoreboard plus
// hand sequences for scanning, sticky hold/clear and asynchronous reset.
module tb_prio_enc_scan;

  localparam int unsigned N        = 16;
  localparam int unsigned DIGITS   = 2;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned IW       = 4;
  localparam int unsigned NV       = 13;

  localparam logic [7:0] DASH = 8'b11111101;
  localparam logic [7:0] S0   = ~8'b11111100;
  localparam logic [7:0] S1   = ~8'b01100000;
  localparam logic [7:0] S4   = ~8'b01100110;
  localparam logic [7:0] S5   = ~8'b10110110;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic              hold  = 1'b0;
  logic              clr   = 1'b0;
  logic [N-1:0]      x     = '0;
  logic [IW-1:0]     y;
  logic              valid;
  logic              chg;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  typedef struct {
    logic        en;
    logic [15:0] x;
    logic [3:0]  y;
    logic        v;
    logic        c;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       v;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  prio_enc_scan #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .hold(hold), .clr(clr),
    .y(y), .valid(valid), .chg(chg), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_display(input string name, input logic [7:0] s0, input logic [7:0] s1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (an == 2'b10)      chk({name, " digit0 seg"}, 32'(seg), 32'(s0));
      else if (an == 2'b01) chk({name, " digit1 seg"}, 32'(seg), 32'(s1));
      else                  chk({name, " an onehot"}, 32'(an), 32'(2'b10));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tv[NV];
    exp_t e;
    tv[0]  = '{1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
    tv[1]  = '{1'b1, 16'h0013, 4'd4,  1'b1, 1'b1};
    tv[2]  = '{1'b1, 16'h0013, 4'd4,  1'b1, 1'b0};
    tv[3]  = '{1'b1, 16'h8001, 4'd15, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 16'h8001, 4'd0,  1'b0, 1'b1};
    tv[5]  = '{1'b0, 16'h8001, 4'd0,  1'b0, 1'b0};
    tv[6]  = '{1'b1, 16'h0001, 4'd0,  1'b1, 1'b1};
    tv[7]  = '{1'b1, 16'h0002, 4'd1,  1'b1, 1'b1};
    tv[8]  = '{1'b1, 16'h0002, 4'd1,  1'b1, 1'b0};
    tv[9]  = '{1'b1, 16'h0200, 4'd9,  1'b1, 1'b1};
    tv[10] = '{1'b1, 16'h0000, 4'd0,  1'b0, 1'b1};
    tv[11] = '{1'b1, 16'h4000, 4'd14, 1'b1, 1'b1};
    tv[12] = '{1'b1, 16'h7FFF, 4'd14, 1'b1, 1'b0};

    // Reset state
    repeat (2) tick();
    chk("reset y", 32'(y), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset chg", 32'(chg), 0);
    chk("reset seg", 32'(seg), 32'hFF);
    chk("reset an", 32'(an), 32'(2'b11));

    // Idle scan: digit 0 for SCAN_DIV clocks, then digit 1, dashes throughout
    en    = 1'b1;
    x     = '0;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("idle an k=%0d", k), 32'(an),
          (((k - 1) / SCAN_DIV) % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
      chk($sformatf("idle seg k=%0d", k), 32'(seg), 32'(DASH));
    end
    chk("idle valid", 32'(valid), 0);

    // Table vectors through the scoreboard, checked two clocks after drive
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d y", i - 2), 32'(y), 32'(e.y));
        chk($sformatf("vec%0d valid", i - 2), 32'(valid), 32'(e.v));
        chk($sformatf("vec%0d chg", i - 2), 32'(chg), 32'(e.c));
      end
      if (i < NV) begin
        en = tv[i].en;
        x  = tv[i].x;
        e.y = tv[i].y;
        e.v = tv[i].v;
        e.c = tv[i].c;
        sb.push_back(e);
      end
      tick();
    end

    // Decimal display with leading zero and two-digit value
    x = 16'h0013;
    repeat (3) tick();
    check_display("y4", S4, S0);
    x = 16'h8001;
    repeat (3) tick();
    check_display("y15", S5, S1);

    // Sticky hold, clear, re-latch, release
    x = '0;
    repeat (3) tick();
    hold = 1'b1;
    x    = 16'h0040;
    tick();
    x = 16'hFFFF;
    tick();
    chk("hold latch y", 32'(y), 6);
    chk("hold latch valid", 32'(valid), 1);
    chk("hold latch chg", 32'(chg), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold keep y", 32'(y), 6);
      chk("hold keep chg", 32'(chg), 0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr y", 32'(y), 0);
    chk("clr valid", 32'(valid), 0);
    chk("clr chg", 32'(chg), 1);
    tick();
    chk("relatch y", 32'(y), 15);
    chk("relatch valid", 32'(valid), 1);
    x = 16'h0001;
    repeat (3) tick();
    chk("relatch keep y", 32'(y), 15);
    chk("relatch keep chg", 32'(chg), 0);
    hold = 1'b0;
    tick();
    chk("release y", 32'(y), 0);
    chk("release valid", 32'(valid), 1);
    chk("release chg", 32'(chg), 1);

    // Asynchronous reset mid-scan
    x = 16'h0200;
    repeat (5) tick();
    chk("pre-reset y", 32'(y), 9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async y", 32'(y), 0);
    chk("async valid", 32'(valid), 0);
    chk("async chg", 32'(chg), 0);
    chk("async seg", 32'(seg), 32'hFF);
    chk("async an", 32'(an), 32'(2'b11));
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart an", 32'(an), 32'(2'b10));
    chk("restart valid", 32'(valid), 0);
    tick();
    chk("restart y", 32'(y), 9);
    chk("restart valid2", 32'(valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
